// File: rtl/ct_f_spsram_256x84_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_256x84_ctrl
//   Request front-end for a 256x84 single-port SRAM. Read/write requests enter
//   on a valid/ready port and are turned into registered SRAM pin activity
//   (A/CEN/GWEN/WEN/D). Read data from Q is collected into an in-order response
//   FIFO. The whole array is zero-cleared after reset (INIT_EN=1) and again
//   whenever init_req is raised while running.
//
// Ports
//   forever_cpuclk, cpurst_b   clock, asynchronous active-low reset
//   init_req / init_done       array clear request (level) / block cleared and in RUN
//   req_*                      request port: valid/ready, wr, idx, half enables, wdata
//   rsp_*                      response port: valid/ready, read data (FIFO head)
//   sram_a/cen/gwen/wen/d      registered SRAM controls (all active low except A/D)
//   sram_q                     SRAM read data, valid two cycles after acceptance
// ---------------------------------------------------------------------------
module ct_f_spsram_256x84_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 84,
  parameter int RSP_DEPTH  = 4,
  parameter int INIT_EN    = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_idx,
  input  logic [1:0]            req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW   = $clog2(RSP_DEPTH + 1);
  localparam int OW   = $clog2(RSP_DEPTH + 3);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_init_done;

  logic [ADDR_WIDTH-1:0] r_sram_a;
  logic                  r_sram_cen;
  logic                  r_sram_gwen;
  logic [DATA_WIDTH-1:0] r_sram_wen;
  logic [DATA_WIDTH-1:0] r_sram_d;

  // Read tracking: p1 = SRAM access cycle, p2 = Q valid cycle (FIFO push).
  logic                  r_rd_p1;
  logic                  r_rd_p2;

  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_fcnt;

  logic [OW-1:0]         w_occ;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_idle_rd;

  // Credit: buffered responses plus reads that will still land in the FIFO.
  assign w_occ     = OW'(r_fcnt) + OW'(r_rd_p1) + OW'(r_rd_p2);
  assign req_rdy   = r_init_done & (r_state == ST_RUN) & ~init_req & (w_occ < OW'(RSP_DEPTH));
  assign w_accept  = req_vld & req_rdy;
  assign w_push    = r_rd_p2;
  assign w_pop     = rsp_vld & rsp_rdy;
  assign w_idle_rd = ~r_rd_p1 & ~r_rd_p2;

  assign init_done = r_init_done;
  assign rsp_vld   = (r_fcnt != '0);
  assign rsp_rdata = r_fifo[r_rptr];
  assign sram_a    = r_sram_a;
  assign sram_cen  = r_sram_cen;
  assign sram_gwen = r_sram_gwen;
  assign sram_wen  = r_sram_wen;
  assign sram_d    = r_sram_d;

  // Control FSM and registered SRAM pins.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      if (INIT_EN != 0) r_state <= ST_INIT;
      else              r_state <= ST_RUN;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_sram_a    <= '0;
      r_sram_cen  <= 1'b1;
      r_sram_gwen <= 1'b1;
      r_sram_wen  <= '1;
      r_sram_d    <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
    end else begin
      r_rd_p1 <= w_accept & ~req_wr;
      r_rd_p2 <= r_rd_p1;

      // Idle access by default; A and D keep their last values.
      r_sram_cen  <= 1'b1;
      r_sram_gwen <= 1'b1;
      r_sram_wen  <= '1;

      case (r_state)
        ST_INIT: begin
          r_sram_a    <= r_cnt;
          r_sram_d    <= '0;
          r_sram_wen  <= '0;
          r_sram_gwen <= 1'b0;
          r_sram_cen  <= 1'b0;
          if (r_cnt == '1) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          r_init_done <= 1'b1;
          if (w_accept) begin
            r_sram_a   <= req_idx;
            r_sram_cen <= 1'b0;
            if (req_wr) begin
              r_sram_gwen <= 1'b0;
              r_sram_d    <= req_wdata;
              r_sram_wen  <= {~{(DATA_WIDTH - HALF){req_be[1]}}, ~{HALF{req_be[0]}}};
            end
          end else if (init_req && w_idle_rd) begin
            // Re-clear only once no read can still push into the FIFO.
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
          end
        end

        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PW'(RSP_DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == PW'(RSP_DEPTH - 1)) ? '0 : r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CW'(1);
        2'b01:   r_fcnt <= r_fcnt - CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; entries are only observed once the
  // occupancy count says they were written.
  always_ff @(posedge forever_cpuclk) begin
    if (w_push) r_fifo[r_wptr] <= sram_q;
  end

endmodule
